// File: rtl/asconp_pkg.sv
// Shared types, tables and helpers for the iterative inverse Ascon permutation.
package asconp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_e;

   // Element [0] is x0 ... element [4] is x4.
   typedef logic [4:0][63:0] state_t;

   localparam logic [4:0] INV_SBOX [32] = '{
      5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
      5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
      5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
      5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
   };

   localparam logic [5:0] ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
   localparam logic [5:0] ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

   function automatic logic [7:0] round_const(input logic [3:0] r);
      return {4'hF - r, r};
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
      logic [127:0] w;
      w = {x, x} >> n;
      return w[63:0];
   endfunction

   // (1 + R^a + R^b)^63 is the inverse because its 64th power is the identity;
   // the 6-bit shift keeps each rotation amount modulo 64.
   function automatic logic [63:0] inv_linear(input logic [63:0] x,
                                              input logic [5:0]  a,
                                              input logic [5:0]  b);
      logic [63:0] y;
      y = x;
      for (int unsigned k = 0; k < 6; k++) begin
         y = y ^ rotr(y, a << k) ^ rotr(y, b << k);
      end
      return y;
   endfunction

endpackage

// File: rtl/asconp_inv_round.sv
// One combinational inverse Ascon round; passes the state through when disabled.
module asconp_inv_round
   import asconp_pkg::*;
(
   input  state_t     x_i,
   input  logic [3:0] rnd_i,
   input  logic       en_i,
   output state_t     x_o
);

   state_t     lin;
   state_t     sb;
   logic [4:0] col;
   logic [4:0] inv;

   always_comb begin
      lin = '0;
      sb  = '0;
      col = '0;
      inv = '0;
      for (int unsigned w = 0; w < 5; w++) begin
         lin[w] = inv_linear(x_i[w], ROT_A[w], ROT_B[w]);
      end
      for (int unsigned j = 0; j < 64; j++) begin
         col      = {lin[0][j], lin[1][j], lin[2][j], lin[3][j], lin[4][j]};
         inv      = INV_SBOX[col];
         sb[0][j] = inv[4];
         sb[1][j] = inv[3];
         sb[2][j] = inv[2];
         sb[3][j] = inv[1];
         sb[4][j] = inv[0];
      end
      sb[2][7:0] = sb[2][7:0] ^ round_const(rnd_i);
      x_o        = en_i ? sb : x_i;
   end

endmodule

// File: rtl/asconp_inv_iter.sv
// Iterative inverse of the N-round Ascon permutation, UROL inverse rounds per cycle,
// with valid/ready handshakes on input and output.
module asconp_inv_iter
   import asconp_pkg::*;
#(
   parameter int unsigned UROL = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [3:0]  rounds_i,
   input  logic [63:0] x0_i,
   input  logic [63:0] x1_i,
   input  logic [63:0] x2_i,
   input  logic [63:0] x3_i,
   input  logic [63:0] x4_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [63:0] x0_o,
   output logic [63:0] x1_o,
   output logic [63:0] x2_o,
   output logic [63:0] x3_o,
   output logic [63:0] x4_o
);

   state_t     state_q, state_d;
   state_t     chain [UROL+1];
   logic [3:0] rnd_q, rnd_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] n_eff;
   logic [3:0] step;
   fsm_e       fsm_q, fsm_d;
   logic       out_valid_q, out_valid_d;
   logic       in_ready_q, in_ready_d;

   assign chain[0] = state_q;

   // Slot g handles round rnd_q-g and is idle once the remaining count runs out.
   for (genvar g = 0; g < UROL; g++) begin : g_round
      asconp_inv_round u_round (
         .x_i   (chain[g]),
         .rnd_i (rnd_q - 4'(g)),
         .en_i  (cnt_q > 4'(g)),
         .x_o   (chain[g+1])
      );
   end

   always_comb n_eff = (rounds_i == 4'd0 || rounds_i > 4'd12) ? 4'd12 : rounds_i;
   always_comb step  = (cnt_q >= 4'(UROL)) ? 4'(UROL) : cnt_q;

   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      rnd_d       = rnd_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid_i && in_ready_q) begin
               state_d    = {x4_i, x3_i, x2_i, x1_i, x0_i};
               rnd_d      = 4'd11;
               cnt_d      = n_eff;
               in_ready_d = 1'b0;
               fsm_d      = RUN;
            end
         end
         RUN: begin
            state_d = chain[UROL];
            rnd_d   = rnd_q - step;
            cnt_d   = cnt_q - step;
            if (cnt_q <= 4'(UROL)) begin
               fsm_d       = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               fsm_d       = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            fsm_d       = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         rnd_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         rnd_q       <= rnd_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign x0_o        = state_q[0];
   assign x1_o        = state_q[1];
   assign x2_o        = state_q[2];
   assign x3_o        = state_q[3];
   assign x4_o        = state_q[4];

endmodule

// File: tb/tb_asconp_inv_iter.sv
// Bench for asconp_inv_iter: a UROL=1 and a UROL=2 instance checked against a
// forward Ascon permutation model by round-tripping.
module tb_asconp_inv_iter;

   typedef logic [4:0][63:0] st_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rounds;
   st_t         din;
   logic        iv1, iv2, or1, or2;
   logic        ir1, ir2, ov1, ov2;
   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] b0, b1, b2, b3, b4;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   asconp_inv_iter #(.UROL(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(iv1), .in_ready_o(ir1), .rounds_i(rounds),
      .x0_i(din[0]), .x1_i(din[1]), .x2_i(din[2]), .x3_i(din[3]), .x4_i(din[4]),
      .out_valid_o(ov1), .out_ready_i(or1),
      .x0_o(a0), .x1_o(a1), .x2_o(a2), .x3_o(a3), .x4_o(a4)
   );

   asconp_inv_iter #(.UROL(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(iv2), .in_ready_o(ir2), .rounds_i(rounds),
      .x0_i(din[0]), .x1_i(din[1]), .x2_i(din[2]), .x3_i(din[3]), .x4_i(din[4]),
      .out_valid_o(ov2), .out_ready_i(or2),
      .x0_o(b0), .x1_o(b1), .x2_o(b2), .x3_o(b3), .x4_o(b4)
   );

   function automatic st_t q_out(input int sel);
      return (sel == 1) ? {a4, a3, a2, a1, a0} : {b4, b3, b2, b1, b0};
   endfunction

   function automatic logic ov(input int sel);
      return (sel == 1) ? ov1 : ov2;
   endfunction

   function automatic logic ir(input int sel);
      return (sel == 1) ? ir1 : ir2;
   endfunction

   task automatic set_iv(input int sel, input logic v);
      if (sel == 1) iv1 = v; else iv2 = v;
   endtask

   task automatic set_or(input int sel, input logic v);
      if (sel == 1) or1 = v; else or2 = v;
   endtask

   function automatic logic [63:0] rr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Forward Ascon permutation, rounds 12-n..11, in the reference bitsliced form.
   function automatic st_t fwd(input st_t s, input int n);
      st_t         x;
      logic [63:0] t [5];
      x = s;
      for (int r = 12 - n; r < 12; r++) begin
         x[2][7:0] = x[2][7:0] ^ {4'(15 - r), 4'(r)};
         x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
         t[0] = ~x[0] & x[1]; t[1] = ~x[1] & x[2]; t[2] = ~x[2] & x[3];
         t[3] = ~x[3] & x[4]; t[4] = ~x[4] & x[0];
         x[0] ^= t[1]; x[1] ^= t[2]; x[2] ^= t[3]; x[3] ^= t[4]; x[4] ^= t[0];
         x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
         x[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
         x[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
         x[2] = x[2] ^ rr(x[2], 1)  ^ rr(x[2], 6);
         x[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
         x[4] = x[4] ^ rr(x[4], 7)  ^ rr(x[4], 41);
      end
      return x;
   endfunction

   function automatic st_t rnd_state();
      st_t s;
      for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
      return s;
   endfunction

   // Offers one vector, waits (bounded) for the result, captures it and acknowledges.
   task automatic run_vec(input int sel, input st_t d, input logic [3:0] rn,
                          output st_t q, output int lat, output logic rdy);
      @(negedge clk);
      rdy    = ir(sel);
      din    = d;
      rounds = rn;
      set_iv(sel, 1'b1);
      @(posedge clk); #1;
      set_iv(sel, 1'b0);
      lat = 0;
      while (!ov(sel) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      q = q_out(sel);
      @(negedge clk);
      set_or(sel, 1'b1);
      @(posedge clk); #1;
      set_or(sel, 1'b0);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks += 6;
      if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_ready1: got %b expected 1", ir1); end
      if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b expected 0", ov1); end
      if (ir2 !== 1'b1) begin errors++; $display("FAIL reset_ready2: got %b expected 1", ir2); end
      if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b expected 0", ov2); end
      if (q_out(1) !== '0) begin errors++; $display("FAIL reset_state1: got %h expected 0", q_out(1)); end
      if (q_out(2) !== '0) begin errors++; $display("FAIL reset_state2: got %h expected 0", q_out(2)); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_zero_p12();
      st_t q; int lat; logic rdy;
      run_vec(1, fwd('0, 12), 4'd12, q, lat, rdy);
      checks += 3;
      if (rdy !== 1'b1) begin errors++; $display("FAIL zero_first_accept: got %b expected 1", rdy); end
      if (lat != 12) begin errors++; $display("FAIL zero_latency: got %0d expected 12", lat); end
      if (q !== '0) begin errors++; $display("FAIL zero_result: got %h expected 0", q); end
   endtask

   task automatic test_roundtrip();
      int  nl [4] = '{1, 6, 8, 12};
      int  el [4] = '{1, 3, 4, 6};
      st_t orig, q; int lat; logic rdy;
      for (int i = 0; i < 4; i++) begin
         for (int v = 0; v < 100; v++) begin
            orig = rnd_state();
            run_vec(2, fwd(orig, nl[i]), 4'(nl[i]), q, lat, rdy);
            checks += 2;
            if (lat != el[i]) begin
               errors++; $display("FAIL u2_latency N=%0d: got %0d expected %0d", nl[i], lat, el[i]);
            end
            if (q !== orig) begin
               errors++; $display("FAIL u2_roundtrip N=%0d: got %h expected %h", nl[i], q, orig);
            end
         end
      end
      for (int n = 1; n <= 11; n++) begin
         orig = rnd_state();
         run_vec(1, fwd(orig, n), 4'(n), q, lat, rdy);
         checks += 2;
         if (lat != n) begin errors++; $display("FAIL u1_latency N=%0d: got %0d expected %0d", n, lat, n); end
         if (q !== orig) begin errors++; $display("FAIL u1_roundtrip N=%0d: got %h expected %h", n, q, orig); end
      end
   endtask

   task automatic test_rounds_alias();
      logic [3:0] rv [4] = '{4'd0, 4'd13, 4'd15, 4'd14};
      int         sv [4] = '{1, 1, 1, 2};
      int         ev [4] = '{12, 12, 12, 6};
      st_t orig, q; int lat; logic rdy;
      for (int i = 0; i < 4; i++) begin
         orig = rnd_state();
         run_vec(sv[i], fwd(orig, 12), rv[i], q, lat, rdy);
         checks += 2;
         if (lat != ev[i]) begin
            errors++; $display("FAIL alias_latency rounds=%0d: got %0d expected %0d", rv[i], lat, ev[i]);
         end
         if (q !== orig) begin
            errors++; $display("FAIL alias_result rounds=%0d: got %h expected %h", rv[i], q, orig);
         end
      end
   endtask

   task automatic test_backpressure();
      st_t orig, q0; int lat;
      orig = rnd_state();
      @(negedge clk);
      din = fwd(orig, 3); rounds = 4'd3; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 40) begin @(posedge clk); #1; lat++; end
      q0 = q_out(1);
      checks += 2;
      if (lat != 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", lat); end
      if (q0 !== orig) begin errors++; $display("FAIL bp_result: got %h expected %h", q0, orig); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         iv1 = 1'b1; din = rnd_state(); rounds = 4'd1;
         @(posedge clk); #1;
         checks += 3;
         if (ov1 !== 1'b1) begin errors++; $display("FAIL bp_valid_hold c=%0d: got %b expected 1", c, ov1); end
         if (q_out(1) !== q0) begin errors++; $display("FAIL bp_data_hold c=%0d: got %h expected %h", c, q_out(1), q0); end
         if (ir1 !== 1'b0) begin errors++; $display("FAIL bp_ready_low c=%0d: got %b expected 0", c, ir1); end
      end
      @(negedge clk);
      iv1 = 1'b0; or1 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0;
      checks += 2;
      if (ov1 !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", ov1); end
      if (ir1 !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", ir1); end
   endtask

   task automatic test_reset_mid_run();
      st_t orig, q; int lat; logic rdy;
      orig = rnd_state();
      @(negedge clk);
      din = fwd(orig, 12); rounds = 4'd12; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks += 3;
      if (ov1 !== 1'b0) begin errors++; $display("FAIL midrun_valid: got %b expected 0", ov1); end
      if (ir1 !== 1'b1) begin errors++; $display("FAIL midrun_ready: got %b expected 1", ir1); end
      if (q_out(1) !== '0) begin errors++; $display("FAIL midrun_state: got %h expected 0", q_out(1)); end
      #2 rst_n = 1'b1;
      orig = rnd_state();
      run_vec(1, fwd(orig, 5), 4'd5, q, lat, rdy);
      checks += 3;
      if (rdy !== 1'b1) begin errors++; $display("FAIL midrun_reaccept: got %b expected 1", rdy); end
      if (lat != 5) begin errors++; $display("FAIL midrun_latency: got %0d expected 5", lat); end
      if (q !== orig) begin errors++; $display("FAIL midrun_result: got %h expected %h", q, orig); end
   endtask

   task automatic test_reset_in_done();
      int lat;
      @(negedge clk);
      din = rnd_state(); rounds = 4'd2; iv2 = 1'b1;
      @(posedge clk); #1;
      iv2 = 1'b0;
      lat = 0;
      while (!ov2 && lat < 40) begin @(posedge clk); #1; lat++; end
      checks += 1;
      if (lat != 1) begin errors++; $display("FAIL done_reach_latency: got %0d expected 1", lat); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (ov2 !== 1'b0) begin errors++; $display("FAIL indone_valid: got %b expected 0", ov2); end
      if (ir2 !== 1'b1) begin errors++; $display("FAIL indone_ready: got %b expected 1", ir2); end
      if (q_out(2) !== '0) begin errors++; $display("FAIL indone_state: got %h expected 0", q_out(2)); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checks += 1;
      if (ov2 !== 1'b0) begin errors++; $display("FAIL indone_stays_idle: got %b expected 0", ov2); end
   endtask

   task automatic test_back_to_back();
      st_t ora, orb, qa; int lat;
      ora = rnd_state();
      orb = rnd_state();
      @(negedge clk);
      din = fwd(ora, 8); rounds = 4'd8; iv2 = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!ov2 && lat < 40) begin
         @(negedge clk);
         din = rnd_state(); rounds = 4'(lat);
         @(posedge clk); #1;
         lat++;
      end
      qa = q_out(2);
      checks += 2;
      if (lat != 4) begin errors++; $display("FAIL b2b_a_latency: got %0d expected 4", lat); end
      if (qa !== ora) begin errors++; $display("FAIL b2b_a_result: got %h expected %h", qa, ora); end
      @(negedge clk);
      din = fwd(orb, 5); rounds = 4'd5; or2 = 1'b1;
      @(posedge clk); #1;
      or2 = 1'b0;
      checks += 2;
      if (ir2 !== 1'b1) begin errors++; $display("FAIL b2b_no_accept_in_handshake: got %b expected 1", ir2); end
      if (ov2 !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", ov2); end
      @(posedge clk); #1;
      iv2 = 1'b0;
      checks += 1;
      if (ir2 !== 1'b0) begin errors++; $display("FAIL b2b_b_accepted: got %b expected 0", ir2); end
      lat = 0;
      while (!ov2 && lat < 40) begin @(posedge clk); #1; lat++; end
      checks += 2;
      if (lat != 3) begin errors++; $display("FAIL b2b_b_latency: got %0d expected 3", lat); end
      if (q_out(2) !== orb) begin errors++; $display("FAIL b2b_b_result: got %h expected %h", q_out(2), orb); end
      @(negedge clk);
      or2 = 1'b1;
      @(posedge clk); #1;
      or2 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; iv1 = 1'b0; iv2 = 1'b0; or1 = 1'b0; or2 = 1'b0;
      rounds = 4'd0; din = '0;
      test_reset();
      test_zero_p12();
      test_roundtrip();
      test_rounds_alias();
      test_backpressure();
      test_reset_mid_run();
      test_reset_in_done();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
